fetch_request_tracker: RTL

Front-end fetch sequencer that sits directly upstream of the instruction metadata / ID management stage. It owns the program counter and issues instruction-memory requests only while an ID is available. It tracks outstanding requests and discards responses belonging to flushed requests. It delivers in-order fetch completions (instruction word plus address-valid flag) to the metadata stage, which writes them into the entry for the current fetch ID.

---
 rtl/fetch_request_tracker_pkg.sv | 17 +
 rtl/fetch_flag_fifo.sv | 39 +++
 rtl/fetch_request_tracker.sv | 111 +++++++++++
 3 files changed

// File: rtl/fetch_request_tracker_pkg.sv
// Shared configuration defaults and types for the fetch request tracker.
// Holds the fetch address-range constants used when FETCH_ADDR_CHECK_EN is defined.
package fetch_request_tracker_pkg;

  localparam logic [31:0] FETCH_RESET_VEC       = 32'h8000_0000;
  localparam int unsigned FETCH_MAX_OUTSTANDING = 2;
  localparam logic [31:0] FETCH_ADDR_LO         = 32'h8000_0000;
  localparam logic [31:0] FETCH_ADDR_HI         = 32'h8000_FFFF;

  // Completion packet handed to the metadata stage.
  typedef struct packed {
    logic        valid;
    logic [31:0] instruction;
    logic        addr_valid;
  } fetch_cpl_t;

endpackage

// File: rtl/fetch_flag_fifo.sv
// 1-bit wide FIFO holding per-request flags in request order.
// The caller guarantees it never pushes when full or pops when empty.
module fetch_flag_fifo #(
  parameter int unsigned DEPTH = 2
) (
  input  logic clk,
  input  logic clear,
  input  logic push,
  input  logic push_data,
  input  logic pop,
  output logic data_out
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PW-1:0] LAST = PW'(DEPTH - 1);

  logic [DEPTH-1:0] mem;
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;

  always_ff @(posedge clk) begin
    if (clear) begin
      mem    <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= (wr_ptr == LAST) ? '0 : wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= (rd_ptr == LAST) ? '0 : rd_ptr + 1'b1;
      end
    end
  end

  assign data_out = mem[rd_ptr];

endmodule

// File: rtl/fetch_request_tracker.sv
// Fetch sequencer: owns the PC, issues ID-gated instruction requests, drops flushed responses.
// Optional FETCH_ADDR_CHECK_EN adds a per-request address-range flag FIFO.
module fetch_request_tracker
  import fetch_request_tracker_pkg::*;
#(
  parameter logic [31:0] RESET_VEC       = FETCH_RESET_VEC,
  parameter int unsigned MAX_OUTSTANDING = FETCH_MAX_OUTSTANDING,
  parameter logic [31:0] ADDR_LO         = FETCH_ADDR_LO,
  parameter logic [31:0] ADDR_HI         = FETCH_ADDR_HI
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        gc_fetch_flush,
  input  logic [31:0] gc_fetch_pc,
  input  logic        fetch_hold,
  input  logic        pc_id_available,
  output logic        pc_id_assigned,
  output logic [31:0] if_pc,
  output logic        mem_req_valid,
  input  logic        mem_req_ready,
  output logic [31:0] mem_req_addr,
  input  logic        mem_rsp_valid,
  input  logic [31:0] mem_rsp_data,
  input  logic        mem_rsp_err,
  output logic        fetch_complete,
  output logic [31:0] fetch_instruction,
  output logic        fetch_address_valid
);

  localparam int OW = $clog2(MAX_OUTSTANDING + 1);
  localparam logic [OW-1:0] MAX_OS = OW'(MAX_OUTSTANDING);

  logic [31:0]   pc;
  logic [OW-1:0] outstanding;
  logic [OW-1:0] discard;
  fetch_cpl_t    cpl_q;
  logic          accept;
  logic          addr_ok;

  assign mem_req_valid  = ~rst & ~gc_fetch_flush & ~fetch_hold & pc_id_available
                        & (outstanding < MAX_OS);
  assign accept         = mem_req_valid & mem_req_ready;
  assign pc_id_assigned = accept;
  assign if_pc          = pc;
  assign mem_req_addr   = pc;

`ifdef FETCH_ADDR_CHECK_EN
  logic range_ok;
  logic range_head;

  assign range_ok = (pc >= ADDR_LO) && (pc <= ADDR_HI);

  // Pops on every response, dropped or not, so it stays aligned with the bus order.
  fetch_flag_fifo #(.DEPTH(MAX_OUTSTANDING)) u_range_fifo (
    .clk       (clk),
    .clear     (rst),
    .push      (accept),
    .push_data (range_ok),
    .pop       (mem_rsp_valid),
    .data_out  (range_head)
  );

  assign addr_ok = range_head & ~mem_rsp_err;
`else
  logic unused_addr_cfg;
  assign unused_addr_cfg = ^{ADDR_LO, ADDR_HI};
  assign addr_ok = ~mem_rsp_err;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      pc          <= RESET_VEC;
      outstanding <= '0;
      discard     <= '0;
      cpl_q       <= '0;
    end else begin
      if (gc_fetch_flush) begin
        pc <= {gc_fetch_pc[31:2], 2'b00};
      end else if (accept) begin
        pc <= pc + 32'd4;
      end

      outstanding <= outstanding + OW'(accept) - OW'(mem_rsp_valid);
      cpl_q.valid <= 1'b0;

      // outstanding already counts responses pending discard, so everything
      // still owed after this cycle's response becomes the new discard count.
      if (gc_fetch_flush) begin
        discard <= outstanding - OW'(mem_rsp_valid);
      end else if (mem_rsp_valid) begin
        if (discard != '0) begin
          discard <= discard - 1'b1;
        end else begin
          cpl_q <= '{valid: 1'b1, instruction: mem_rsp_data, addr_valid: addr_ok};
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && mem_rsp_valid) begin
      assert (outstanding != '0)
        else $error("fetch response received with no request outstanding");
    end
  end

  assign fetch_complete      = cpl_q.valid;
  assign fetch_instruction   = cpl_q.instruction;
  assign fetch_address_valid = cpl_q.addr_valid;

endmodule
